// File: rtl/vga_text_writer.sv
// vga_text_writer
//   Wishbone initiator that turns a stream of character codes into writes to
//   the 80x25 text buffer of the VGA text adapter. Row 0 is the status line
//   and is never touched; the cursor lives in rows 1..ROWS-1. Handles CR, LF,
//   BS and FF, and scrolls rows 1..ROWS-1 up by one with word read/write copies.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wb_adr_o/dat_o/dat_i   byte address, write data, read data
//   wb_cyc_o, wb_stb_o     bus cycle / strobe (always driven together)
//   wb_we_o, wb_sel_o      write enable, byte lanes ([0] even, [1] odd)
//   wb_ack_i               responder acknowledge
//   char_i, char_valid_i   incoming character code and its valid
//   char_ready_o           high only while idle
//   cursor_o               cursor byte offset row*COLS+col
//   busy_o                 high while a code is being processed
module vga_text_writer #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter int          COLS = 80,
  parameter int          ROWS = 25,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [12:0] cursor_o,
  output logic        busy_o
);

  localparam int CW = $clog2(COLS);
  localparam logic [12:0]   L_COLS     = 13'(COLS);
  localparam logic [12:0]   L_LASTROW  = 13'((ROWS - 1) * COLS);
  localparam logic [12:0]   L_LASTCELL = 13'(ROWS * COLS - 1);
  localparam logic [12:0]   L_SCR_END  = 13'((ROWS - 1) * COLS - 2);
  localparam logic [12:0]   L_BUF_END  = 13'(ROWS * COLS - 2);
  localparam logic [CW-1:0] L_COLMAX   = CW'(COLS - 1);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_SCR_CLR, S_CLR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [12:0]   r_cur;
  logic [CW-1:0] r_col;     // column kept alongside the cursor to avoid a divider
  logic [12:0]   r_ptr;     // destination offset of the scroll/clear word loop
  logic [7:0]    r_char;
  logic [15:0]   r_rdata;
  logic          r_wrap;    // scroll was caused by writing the last cell
  logic          r_stb;
  logic          r_we;
  logic [15:0]   r_adr;
  logic [15:0]   r_dat;
  logic [1:0]    r_sel;

  logic          w_accept;
  logic          w_done;
  logic          w_launch;
  logic          w_lf_room;
  logic [12:0]   w_off;

  assign w_accept  = char_valid_i && (r_state == S_IDLE);
  assign w_done    = r_stb && wb_ack_i;
  // A new access starts only while strobe is low, so after every ack the
  // strobe spends at least one full clock deasserted.
  assign w_launch  = (r_state != S_IDLE) && !r_stb;
  assign w_lf_room = r_cur < L_LASTROW;

  always_comb begin
    w_off = r_ptr;
    case (r_state)
      S_PUT:    w_off = r_cur;
      S_SCR_RD: w_off = r_ptr + L_COLS;
      default:  w_off = r_ptr;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (char_valid_i) begin
          case (char_i)
            C_LF:       w_state_nxt = w_lf_room ? S_IDLE : S_SCR_RD;
            C_FF:       w_state_nxt = S_CLR;
            C_CR, C_BS: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_PUT;
          endcase
        end
      end
      S_PUT:     if (w_done) w_state_nxt = (r_cur == L_LASTCELL) ? S_SCR_RD : S_IDLE;
      S_SCR_RD:  if (w_done) w_state_nxt = S_SCR_WR;
      S_SCR_WR:  if (w_done) w_state_nxt = (r_ptr == L_SCR_END) ? S_SCR_CLR : S_SCR_RD;
      S_SCR_CLR: if (w_done && (r_ptr == L_BUF_END)) w_state_nxt = S_IDLE;
      S_CLR:     if (w_done && (r_ptr == L_BUF_END)) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cur   <= L_COLS;
      r_col   <= '0;
      r_ptr   <= L_COLS;
      r_char  <= '0;
      r_rdata <= '0;
      r_wrap  <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
    end else begin
      if (w_accept) begin
        r_char <= char_i;
        case (char_i)
          C_CR: begin
            r_cur <= r_cur - 13'(r_col);
            r_col <= '0;
          end
          C_LF: begin
            if (w_lf_room) r_cur <= r_cur + L_COLS;
            else           r_ptr <= L_COLS;
          end
          C_BS: begin
            if (r_cur > L_COLS) begin
              r_cur <= r_cur - 13'd1;
              r_col <= (r_col == '0) ? L_COLMAX : r_col - CW'(1);
            end
          end
          C_FF:    r_ptr <= L_COLS;
          default: ;
        endcase
      end

      if (w_launch) begin
        r_stb <= 1'b1;
        r_adr <= BASE + {3'b000, w_off};
        r_we  <= (r_state != S_SCR_RD);
        case (r_state)
          S_PUT: begin
            r_sel <= r_cur[0] ? 2'b10 : 2'b01;
            r_dat <= {r_char, r_char};
          end
          S_SCR_WR: begin
            r_sel <= 2'b11;
            r_dat <= r_rdata;
          end
          default: begin
            r_sel <= 2'b11;
            r_dat <= {FILL, FILL};
          end
        endcase
      end

      if (w_done) begin
        r_stb <= 1'b0;
        case (r_state)
          S_PUT: begin
            if (r_cur == L_LASTCELL) begin
              r_ptr  <= L_COLS;
              r_wrap <= 1'b1;
            end else begin
              r_cur <= r_cur + 13'd1;
              r_col <= (r_col == L_COLMAX) ? '0 : r_col + CW'(1);
            end
          end
          S_SCR_RD: r_rdata <= wb_dat_i;
          S_SCR_WR: begin
            if (r_ptr == L_SCR_END) r_ptr <= L_LASTROW;
            else                    r_ptr <= r_ptr + 13'd2;
          end
          S_SCR_CLR: begin
            if (r_ptr == L_BUF_END) begin
              // An LF scroll leaves the cursor where it was; a scroll caused by
              // the last cell moves it to the start of the freshly cleared row.
              if (r_wrap) begin
                r_cur <= L_LASTROW;
                r_col <= '0;
              end
              r_wrap <= 1'b0;
            end else begin
              r_ptr <= r_ptr + 13'd2;
            end
          end
          S_CLR: begin
            if (r_ptr == L_BUF_END) begin
              r_cur <= L_COLS;
              r_col <= '0;
            end else begin
              r_ptr <= r_ptr + 13'd2;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_cyc_o     = r_stb;
  assign wb_stb_o     = r_stb;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = r_sel;
  assign cursor_o     = r_cur;
  assign busy_o       = (r_state != S_IDLE);
  assign char_ready_o = (r_state == S_IDLE);

endmodule

// File: tb/tb_vga_text_writer.sv
module tb_vga_text_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] adr, dat_o, dat_i;
  logic        cyc, stb, we, ack;
  logic [1:0]  sel;
  logic [7:0]  char_c;
  logic        valid, ready, busy;
  logic [12:0] cursor;

  vga_text_writer dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wb_adr_o    (adr),
    .wb_dat_o    (dat_o),
    .wb_dat_i    (dat_i),
    .wb_cyc_o    (cyc),
    .wb_stb_o    (stb),
    .wb_we_o     (we),
    .wb_sel_o    (sel),
    .wb_ack_i    (ack),
    .char_i      (char_c),
    .char_valid_i(valid),
    .char_ready_o(ready),
    .cursor_o    (cursor),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int lat   = 0;
  int rcnt  = 0;
  int m_cur;
  logic [15:0] mem     [0:1023];
  logic [15:0] exp_mem [0:1023];
  logic [34:0] sbq [$];
  logic [34:0] t_act;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Responder: acks after 'lat' waiting clocks, holds ack for one clock,
  // serves reads from and commits writes to its own word memory.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack  = 1'b0;
      rcnt = 0;
    end else if (ack) begin
      ack = 1'b0;
      check_eq("stb_gap", {62'd0, cyc, stb}, 64'd0);
    end else if (cyc && stb) begin
      if (rcnt >= lat) begin
        t_act = {we, adr, sel, (we ? dat_o : 16'h0000)};
        if (!we) begin
          dat_i = mem[adr[10:1]];
        end else begin
          if (sel[0]) mem[adr[10:1]][7:0]  = dat_o[7:0];
          if (sel[1]) mem[adr[10:1]][15:8] = dat_o[15:8];
        end
        check_eq("rdy_busy", {62'd0, ready, busy}, 64'd1);
        if (sbq.size() == 0) check_eq("unexpected_xfer", 64'(t_act), 64'd0);
        else                 check_eq("xfer", 64'(t_act), 64'(sbq.pop_front()));
        ack  = 1'b1;
        rcnt = 0;
      end else begin
        rcnt++;
      end
    end else if (rcnt != 0) begin
      check_eq("stb_hold", {63'd0, stb}, 64'd1);
      rcnt = 0;
    end
  end

  task automatic model_write(input int off, input logic [1:0] s, input logic [15:0] d);
    sbq.push_back({1'b1, 16'(off), s, d});
    if (s[0]) exp_mem[off/2][7:0]  = d[7:0];
    if (s[1]) exp_mem[off/2][15:8] = d[15:8];
  endtask

  task automatic model_scroll();
    for (int dst = 80; dst <= 1918; dst += 2) begin
      sbq.push_back({1'b0, 16'(dst + 80), 2'b11, 16'h0000});
      model_write(dst, 2'b11, exp_mem[(dst + 80) / 2]);
    end
    for (int a = 1920; a <= 1998; a += 2) model_write(a, 2'b11, 16'h2020);
  endtask

  task automatic model_char(input logic [7:0] c);
    case (c)
      8'h0D: m_cur = m_cur - (m_cur % 80);
      8'h0A: if (m_cur < 1920) m_cur = m_cur + 80; else model_scroll();
      8'h08: if (m_cur > 80) m_cur = m_cur - 1;
      8'h0C: begin
        for (int a = 80; a <= 1998; a += 2) model_write(a, 2'b11, 16'h2020);
        m_cur = 80;
      end
      default: begin
        model_write(m_cur, (m_cur % 2 == 1) ? 2'b10 : 2'b01, {c, c});
        if (m_cur == 1999) begin
          model_scroll();
          m_cur = 1920;
        end else begin
          m_cur = m_cur + 1;
        end
      end
    endcase
  endtask

  task automatic offer(input logic [7:0] c);
    int k;
    model_char(c);
    @(negedge clk);
    char_c = c;
    valid  = 1'b1;
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check_eq("accept_timeout", 64'(ready), 64'd1);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    int w;
    offer(c);
    @(negedge clk);
    w = 0;
    while (busy && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check_eq("idle", 64'(busy), 64'd0);
    check_eq("cursor", 64'(cursor), 64'(m_cur));
    check_eq("ready", 64'(ready), 64'd1);
    check_eq("sb_left", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = {8'(i), 8'(i >> 2) + 8'h40};
      exp_mem[i] = {8'(i), 8'(i >> 2) + 8'h40};
    end
    rst_n  = 1'b0;
    ack    = 1'b0;
    dat_i  = 16'h0000;
    char_c = 8'h00;
    valid  = 1'b0;
    m_cur  = 80;
    repeat (3) @(negedge clk);
    check_eq("rst_cursor", 64'(cursor), 64'd80);
    check_eq("rst_ctl", {59'd0, cyc, stb, we, ready, busy}, 64'h2);
    check_eq("rst_bus", {30'd0, adr, dat_o, sel}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single glyphs, second one against a slow responder
    send(8'h41);
    lat = 5;
    send(8'h42);
    lat = 0;

    // control codes, control-range glyph, column wrap
    send(8'h0D);
    send(8'h0A);
    send(8'h01);
    send(8'h43);
    send(8'h44);
    send(8'h45);
    send(8'h46);
    send(8'h0D);
    send(8'h0A);
    send(8'h08);
    send(8'h47);
    send(8'h0D);
    send(8'h0C);
    send(8'h08);

    // fill to the last cell, then a glyph there forces a scroll
    for (int i = 0; i < 23; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 40));
    send(8'h5A);

    // reset in the middle of an LF scroll
    offer(8'h0A);
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cyc_stb", {62'd0, cyc, stb}, 64'd0);
    check_eq("arst_cursor", 64'(cursor), 64'd80);
    check_eq("arst_busy", 64'(busy), 64'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_cur = 80;
    @(negedge clk);
    send(8'h41);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
